// File: rtl/pll_lock_reset_sequencer.sv
// Lock qualification and staggered reset release for one PLL output clock domain.
// Optional lock-acquire timeout flag is built when PLL_LOCK_TIMEOUT_EN is defined.
module pll_lock_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int NUM_RESETS     = 4,
    parameter int STAGGER_CYCLES = 16,
    parameter int LOSS_CNT_W     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock_in,
    input  logic                  rst_in,
    input  logic                  pll_lock_in,
    input  logic                  resequence_in,
    output logic                  locked,
    output logic [NUM_RESETS-1:0] rst_out,
    output logic                  seq_done,
    output logic [LOSS_CNT_W-1:0] loss_count,
`ifdef PLL_LOCK_TIMEOUT_EN
    output logic                  lock_timeout,
`endif
    output logic [2:0]            fsm_state_o
);

    localparam int STB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int STG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam int IDX_W = (NUM_RESETS > 1) ? $clog2(NUM_RESETS) : 1;
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_RESETS - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 ||
        NUM_RESETS < 1 || NUM_RESETS > 16 || STAGGER_CYCLES < 1 || STAGGER_CYCLES > 65535 ||
        LOSS_CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pll_lock_reset_sequencer: parameter out of legal range");
    end

    // RESTART holds all resets for one cycle after a resequence before bit 0 is released again.
    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_QUALIFY   = 3'd1,
        S_RELEASE   = 3'd2,
        S_RESTART   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t                  state_q;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [STB_W-1:0]        stable_q;
    logic [STG_W-1:0]        stagger_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    locked_q;
    logic [NUM_RESETS-1:0]   rst_q;
    logic                    done_q;
    logic [LOSS_CNT_W-1:0]   loss_q;

    logic                    lock_s;
    logic                    in_seq;
    logic                    lost_d;
    logic                    reseq_d;
    logic                    qualify_d;
    logic                    start_rel_d;
    logic [IDX_W-1:0]        next_idx_d;

    always_comb begin
        lock_s      = sync_q[SYNC_STAGES-1];
        in_seq      = (state_q == S_RELEASE) || (state_q == S_RESTART) || (state_q == S_RUN);
        lost_d      = in_seq && !lock_s;
        reseq_d     = in_seq && lock_s && resequence_in;
        // The WAIT_LOCK cycle that first sees lock_s counts as the first stable cycle.
        qualify_d   = lock_s && ((state_q == S_WAIT_LOCK) || (state_q == S_QUALIFY)) &&
                      (stable_q == STB_LAST);
        start_rel_d = qualify_d || (state_q == S_RESTART);
        next_idx_d  = idx_q + IDX_W'(1);
    end

    always_ff @(posedge clock_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q    <= '0;
            state_q   <= S_WAIT_LOCK;
            stable_q  <= '0;
            stagger_q <= '0;
            idx_q     <= '0;
            locked_q  <= 1'b0;
            rst_q     <= '1;
            done_q    <= 1'b0;
            loss_q    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_in};
            if (lost_d) begin
                state_q   <= S_WAIT_LOCK;
                locked_q  <= 1'b0;
                rst_q     <= '1;
                done_q    <= 1'b0;
                stable_q  <= '0;
                stagger_q <= '0;
                idx_q     <= '0;
                if (loss_q != {LOSS_CNT_W{1'b1}}) begin
                    loss_q <= loss_q + LOSS_CNT_W'(1);
                end
            end else if (reseq_d) begin
                state_q   <= S_RESTART;
                rst_q     <= '1;
                done_q    <= 1'b0;
                stagger_q <= '0;
                idx_q     <= '0;
            end else if (start_rel_d) begin
                locked_q  <= 1'b1;
                stable_q  <= '0;
                stagger_q <= '0;
                idx_q     <= '0;
                rst_q[0]  <= 1'b0;
                if (NUM_RESETS == 1) begin
                    state_q <= S_RUN;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_RELEASE;
                end
            end else begin
                case (state_q)
                    S_WAIT_LOCK, S_QUALIFY: begin
                        if (lock_s) begin
                            stable_q <= stable_q + STB_W'(1);
                            state_q  <= S_QUALIFY;
                        end else begin
                            stable_q <= '0;
                            state_q  <= S_WAIT_LOCK;
                        end
                    end
                    S_RELEASE: begin
                        if (stagger_q == STG_LAST) begin
                            stagger_q         <= '0;
                            idx_q             <= next_idx_d;
                            rst_q[next_idx_d] <= 1'b0;
                            if (next_idx_d == IDX_LAST) begin
                                state_q <= S_RUN;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            stagger_q <= stagger_q + STG_W'(1);
                        end
                    end
                    S_RUN: begin
                    end
                    default: state_q <= S_WAIT_LOCK;
                endcase
            end
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;

    // Counter holds at its terminal value so the flag stays sticky while waiting.
    always_ff @(posedge clock_in or posedge rst_in) begin
        if (rst_in) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (qualify_d) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if ((state_q == S_WAIT_LOCK) || (state_q == S_QUALIFY)) begin
            if (to_cnt_q == TO_LAST) begin
                timeout_q <= 1'b1;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

    assign lock_timeout = timeout_q;
`endif

    assign locked      = locked_q;
    assign rst_out     = rst_q;
    assign seq_done    = done_q;
    assign loss_count  = loss_q;
    assign fsm_state_o = state_q;

endmodule

// File: doc/pll_lock_reset_sequencer.md
Name: pll_lock_reset_sequencer

Overview:
Generalised lock-qualification and reset-release block, sitting in the PLL output clock domain beside each CC_PLL/CC_BUFG instance. It synchronises the raw PLL lock, debounces it over a configurable stable window, then releases NUM_RESETS active-high domain resets one at a time with a programmable stagger. Lock loss re-asserts all resets at once and counts the event. A software re-sequence request is also supported.

Parameters:
SYNC_STAGES, 2, flip-flop stages on pll_lock_in; legal range 2..4.
STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before qualifying lock; legal range 1..65535.
NUM_RESETS, 4, number of staggered reset outputs; legal range 1..16.
STAGGER_CYCLES, 16, cycles between consecutive reset releases; legal range 1..65535.
LOSS_CNT_W, 8, width of the lock-loss event counter.
TIMEOUT_CYCLES, 1000000, lock-acquire timeout; used only with LOCK_TIMEOUT_EN.

Ports:
clock_in  in  1  PLL output clock (post-BUFG); the only clock.
rst_in  in  1  asynchronous, active-high reset.
pll_lock_in  in  1  raw PLL lock (USR_PLL_LOCKED), asynchronous to clock_in.
resequence_in  in  1  synchronous single-cycle request to re-run the release sequence.
locked  out  1  qualified lock, registered.
rst_out  out  NUM_RESETS  active-high domain resets; bit 0 is released first.
seq_done  out  1  high once all rst_out bits are released.
loss_count  out  LOSS_CNT_W  qualified-lock-loss events; saturates at all-ones.
lock_timeout  out  1  acquire timeout flag; present only with LOCK_TIMEOUT_EN.

Behaviour:
- Reset (rst_in high, asynchronous): sync chain=0, FSM=WAIT_LOCK, locked=0, rst_out=all ones, seq_done=0, loss_count=0, counters=0, lock_timeout=0.
- lock_s is the last stage of the SYNC_STAGES chain. Raw lock edge to lock_s takes SYNC_STAGES cycles.
- FSM states:
  - WAIT_LOCK: stable counter=0. When lock_s=1, go to QUALIFY.
  - QUALIFY: stable counter increments each cycle while lock_s=1. If lock_s=0, clear the counter and return to WAIT_LOCK; this is not a loss event. In the cycle the counter reaches STABLE_CYCLES-1 with lock_s=1, set locked=1 next edge and go to RELEASE with stagger counter=0 and index=0. Rising edge of lock_s to locked=1 is exactly STABLE_CYCLES cycles.
  - RELEASE: rst_out[index] is cleared on entry. Stagger counter then counts STAGGER_CYCLES cycles, after which the next bit clears. Bit k clears k*STAGGER_CYCLES cycles after bit 0. After the last bit clears, go to RUN and set seq_done=1 in that same edge.
  - RUN: hold all outputs.
- Lock loss (lock_s=0 in RELEASE or RUN): the next edge sets rst_out=all ones, locked=0, seq_done=0, and increments loss_count (saturating), then goes to WAIT_LOCK. Loss takes priority over every other event in the same cycle.
- resequence_in=1 in RUN or RELEASE with lock_s=1: next edge sets rst_out=all ones and seq_done=0, keeps locked=1, does not increment loss_count, and restarts RELEASE at index 0. resequence_in is ignored in WAIT_LOCK and QUALIFY.
- rst_out bits change only on clock edges, except on assertion by rst_in. Once released, a bit never clears again; it re-asserts only on loss, resequence or rst_in.
- NUM_RESETS=1: seq_done rises in the same edge that rst_out[0] clears.
- All counters are sized by $clog2 of their limits; no wrap is permitted before the terminal count.

Optional Feature:
Macro: PLL_LOCK_TIMEOUT_EN.
- Defined: a timeout counter runs while the FSM is in WAIT_LOCK or QUALIFY and clears on entering RELEASE or on rst_in. When it reaches TIMEOUT_CYCLES, lock_timeout is set and stays sticky until rst_in or until locked rises. The FSM continues waiting regardless.
- Undefined: the lock_timeout port, its counter and the TIMEOUT_CYCLES logic are absent.

Test Plan:
- Basic acquire (STABLE_CYCLES=8, STAGGER_CYCLES=4, NUM_RESETS=4): raise pll_lock_in at cycle 0 -> locked=1 at cycle 2+8; rst_out bits clear at +0/+4/+8/+12 after locked; seq_done rises with bit 3.
- Glitchy lock: pulse pll_lock_in high for 5 cycles, low for 1, then high -> no locked, loss_count=0, qualification restarts; locked asserts 8 cycles after the final rising edge of lock_s.
- Lock loss in RUN: drop pll_lock_in -> SYNC_STAGES+1 edges later rst_out=4'b1111, locked=0, loss_count=1; re-lock reruns the full sequence. Lock loss mid-RELEASE after bit 1 clears -> all bits re-assert, loss_count=2.
- Resequence in RUN: pulse resequence_in -> rst_out=4'b1111 and seq_done=0 next edge, locked stays 1, restaggered release, loss_count unchanged. A pulse during QUALIFY -> no effect.
- Saturation and async reset (LOSS_CNT_W=2): 5 loss events -> loss_count=2'b11. Assert rst_in mid-RELEASE -> all outputs immediately at reset values without waiting for a clock edge.
- PLL_LOCK_TIMEOUT_EN with TIMEOUT_CYCLES=50, lock held low -> lock_timeout=1 at cycle 50 and stays high. Lock then acquired -> lock_timeout clears when locked rises.
